// File: rtl/aes_pkg.sv
// Types and byte-index helpers shared by the serial (Inv)ShiftRows/(Inv)SubBytes units.
// Byte i of a state sits at packed index NBYTES-1-i, matching the bus layout in_state[127-8i -: 8].
package aes_pkg;

    localparam int NB     = 4;
    localparam int NBYTES = 16;

    typedef logic [7:0]              byte_t;
    typedef logic [NBYTES-1:0][7:0]  state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_e;

    // Column-major byte k (row k%NB, col k/NB) of InvShiftRows output comes from this input byte.
    function automatic logic [3:0] src_index(input logic [3:0] k);
        int r;
        int c;
        r = int'(k) % NB;
        c = int'(k) / NB;
        return 4'(r + NB * ((c - r + NB) % NB));
    endfunction

    function automatic logic [3:0] fwd_src_index(input logic [3:0] k);
        int r;
        int c;
        r = int'(k) % NB;
        c = int'(k) / NB;
        return 4'(r + NB * ((c + r) % NB));
    endfunction

endpackage

// File: rtl/subByte.sv
// AES S-box, forward or inverse selected by inv.
// Built as GF(2^8) inversion plus the affine map rather than a stored table.
module subByte
    import aes_pkg::*;
(
    input  logic  inv,
    input  byte_t in_byte,
    output byte_t out_byte
);

    function automatic byte_t rotl(input byte_t x, input int unsigned n);
        return byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        byte_t bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t p;
        byte_t r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    byte_t pre;
    byte_t inv_out;

    always_comb begin
        pre      = inv ? (rotl(in_byte, 1) ^ rotl(in_byte, 3) ^ rotl(in_byte, 6) ^ 8'h05)
                       : in_byte;
        inv_out  = gf_inv(pre);
        out_byte = inv ? inv_out
                       : (inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2)
                          ^ rotl(inv_out, 3) ^ rotl(inv_out, 4) ^ 8'h63);
    end

endmodule

// File: rtl/inv_sub_shift_serial.sv
// Byte-serial InvShiftRows + InvSubBytes: one shared inverse S-box, 16 RUN cycles per state.
// The two transforms commute, so each output byte is a single lookup of a permuted input byte.
module inv_sub_shift_serial
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    fsm_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     in_buf_q, in_buf_d;
    state_t     out_q, out_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    logic [3:0] src_pos;
    logic [3:0] dst_pos;
    byte_t      sbox_in;
    byte_t      sbox_out;

    always_comb begin
        src_pos = 4'(NBYTES - 1) - src_index(cnt_q);
        dst_pos = 4'(NBYTES - 1) - cnt_q;
        sbox_in = in_buf_q[src_pos];
    end

    subByte u_inv_sbox (
        .inv      (1'b1),
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_buf_d    = in_buf_q;
        out_d       = out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_buf_d   = in_state;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                out_d[dst_pos] = sbox_out;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(NBYTES - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_buf_q    <= in_buf_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// Directed bench for inv_sub_shift_serial; random stream checked against a table-based reference.
module tb_inv_sub_shift_serial;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    localparam logic [127:0] VEC     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_EXP = 128'h52f3a3383009d79ebf366afb8140a5d5;
    localparam logic [127:0] ALL63   = {16{8'h63}};
    localparam logic [127:0] ALL52   = {16{8'h52}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;
    logic         busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    inv_sub_shift_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] res;
        int r;
        int c;
        int src;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            r   = k % 4;
            c   = k / 4;
            src = r + 4 * ((c - r + 4) % 4);
            res[127-8*k -: 8] = INV_SBOX[s[127-8*src -: 8]];
        end
        return res;
    endfunction

    // Leaves in_valid low after the acceptance edge; acc is the cycle count at that edge.
    task automatic accept(input logic [127:0] s, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        in_state = s;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", {127'd0, out_valid}, 128'd1);
        lat = cyc - acc;
    endtask

    task automatic handshake(input logic [127:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_in_ready", {127'd0, in_ready}, 128'd1);
        check("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
        check("post_hs_out_hold", out_state, exp);
    endtask

    task automatic run_block(input string tag, input logic [127:0] s, input logic [127:0] exp,
                             input bit noise);
        int acc;
        int lat;
        accept(s, acc);
        if (noise) begin
            in_state = ~s;
            in_valid = 1'b1;
            repeat (8) @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_noise_in_ready"}, {127'd0, in_ready}, 128'd0);
        end
        wait_out(acc, lat);
        check({tag, "_latency"}, 128'(lat), 128'd16);
        check({tag, "_data"}, out_state, exp);
        check({tag, "_busy_done"}, {127'd0, busy}, 128'd1);
        check({tag, "_in_ready_done"}, {127'd0, in_ready}, 128'd0);
        handshake(exp);
    endtask

    initial begin
        int acc;
        int lat;
        logic [127:0] blk [4];
        logic [127:0] got [4];
        int acc_t [4];

        repeat (2) @(negedge clk);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_out_state", out_state, '0);
        rst_n = 1'b1;

        run_block("all63", ALL63, '0, 1'b0);
        run_block("all00", '0, ALL52, 1'b1);
        run_block("vec", VEC, VEC_EXP, 1'b0);

        // Stall in DONE while a new block waits at the input.
        accept(ALL63, acc);
        wait_out(acc, lat);
        in_state = VEC;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", {127'd0, out_valid}, 128'd1);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            check("stall_out_state", out_state, '0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_hs_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
        check("stall_next_busy", {127'd0, busy}, 128'd1);
        check("stall_next_in_ready", {127'd0, in_ready}, 128'd0);
        wait_out(acc, lat);
        check("stall_next_latency", 128'(lat), 128'd16);
        check("stall_next_data", out_state, VEC_EXP);
        handshake(VEC_EXP);

        // Asynchronous reset in the middle of RUN.
        accept(ALL63, acc);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_out_state", out_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block("after_rst", VEC, VEC_EXP, 1'b0);

        // Back-to-back stream with out_ready held high.
        for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        fork
            begin : drive_stream
                for (int i = 0; i < 4; i++) accept(blk[i], acc_t[i]);
            end
            begin : collect_stream
                int n;
                for (int i = 0; i < 4; i++) begin
                    n = 0;
                    while (!out_valid && n < 80) begin
                        @(negedge clk);
                        n++;
                    end
                    check("stream_out_valid_seen", {127'd0, out_valid}, 128'd1);
                    got[i] = out_state;
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stream_data", got[i], model(blk[i]));
            if (i > 0) check("stream_interval", 128'(acc_t[i] - acc_t[i-1]), 128'd18);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
